// File: rtl/gen_clk_multi.sv
// rtl/gen_clk_multi.sv - multi-output binary clock divider with frame strobe and lock flag
// clk_out is the counter itself, so every divided clock is glitch-free and edge-aligned.
module gen_clk_multi #(
   parameter int NUM_OUT      = 3,
   parameter int LOCK_PERIODS = 2
) (
   input  logic               clk_8f,
   input  logic               rst,
   input  logic               enb,
   output logic [NUM_OUT-1:0] clk_out,
   output logic               sync_out,
   output logic               running,
   output logic               locked
);

   localparam logic [NUM_OUT-1:0] CNT_MAX  = '1;
   localparam logic [3:0]         LOCK_TGT = 4'(LOCK_PERIODS);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [NUM_OUT-1:0] cnt;
   logic [NUM_OUT-1:0] cnt_nx;
   logic [3:0]         lock_cnt;
   logic [3:0]         lock_nx;

   always_ff @(posedge clk_8f) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         lock_cnt <= '0;
         sync_out <= 1'b0;
         running  <= 1'b0;
         locked   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         lock_cnt <= lock_nx;
         // Flags are registered from next-state values so they align with cnt.
         sync_out <= (state_nx == S_RUN) && (cnt_nx == CNT_MAX);
         running  <= (state_nx == S_RUN);
         locked   <= (lock_nx == LOCK_TGT);
      end
   end

   assign clk_out = cnt;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      lock_nx  = lock_cnt;
      case (state)
         S_IDLE: begin
            if (enb) state_nx = S_RUN;
         end
         S_RUN: begin
            // Natural wrap from CNT_MAX to 0 drops every output on the same edge.
            cnt_nx = cnt + NUM_OUT'(1);
            if (enb) begin
               if (cnt == CNT_MAX && lock_cnt != LOCK_TGT) lock_nx = lock_cnt + 4'd1;
            end else begin
               // Drain: finish the current slowest period so no pulse is truncated.
               lock_nx = '0;
               if (cnt == CNT_MAX) state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_gen_clk_multi.sv
// tb/tb_gen_clk_multi.sv - scoreboard bench for gen_clk_multi (default and 1-output/1-period builds)
module tb_gen_clk_multi;

   logic       clk_8f = 1'b0;
   logic       rst    = 1'b1;
   logic       enb    = 1'b0;
   logic [2:0] clk_a;
   logic       sync_a, run_a, lock_a;
   logic       clk_b;
   logic       sync_b, run_b, lock_b;

   int errors = 0;
   int checks = 0;

   always #5 clk_8f = ~clk_8f;

   gen_clk_multi dut_a (
      .clk_8f(clk_8f), .rst(rst), .enb(enb),
      .clk_out(clk_a), .sync_out(sync_a), .running(run_a), .locked(lock_a)
   );

   gen_clk_multi #(.NUM_OUT(1), .LOCK_PERIODS(1)) dut_b (
      .clk_8f(clk_8f), .rst(rst), .enb(enb),
      .clk_out(clk_b), .sync_out(sync_b), .running(run_b), .locked(lock_b)
   );

   typedef struct {
      int clk_a;
      int sync_a;
      int run_a;
      int lock_a;
      int clk_b;
      int sync_b;
      int run_b;
      int lock_b;
   } exp_t;

   exp_t exp_q[$];

   int ma_cnt = 0, ma_run = 0, ma_lock = 0;
   int mb_cnt = 0, mb_run = 0, mb_lock = 0;

   task automatic check_eq(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_step(input int r, input int e, input int cmax, input int lp,
                             inout int cnt, inout int run, inout int lock);
      if (r != 0) begin
         cnt = 0; run = 0; lock = 0;
      end else if (run == 0) begin
         if (e != 0) run = 1;
      end else if (e != 0) begin
         if (cnt == cmax) begin
            cnt = 0;
            if (lock < lp) lock++;
         end else cnt++;
      end else begin
         lock = 0;
         if (cnt == cmax) begin
            cnt = 0; run = 0;
         end else cnt++;
      end
   endtask

   task automatic cycle(input int r, input int e);
      exp_t x;
      @(negedge clk_8f);
      rst = r[0];
      enb = e[0];
      @(posedge clk_8f);
      model_step(r, e, 7, 2, ma_cnt, ma_run, ma_lock);
      model_step(r, e, 1, 1, mb_cnt, mb_run, mb_lock);
      x.clk_a  = ma_cnt;
      x.sync_a = (ma_run != 0 && ma_cnt == 7) ? 1 : 0;
      x.run_a  = ma_run;
      x.lock_a = (ma_lock == 2) ? 1 : 0;
      x.clk_b  = mb_cnt;
      x.sync_b = (mb_run != 0 && mb_cnt == 1) ? 1 : 0;
      x.run_b  = mb_run;
      x.lock_b = (mb_lock == 1) ? 1 : 0;
      exp_q.push_back(x);
      #1;
   endtask

   always @(negedge clk_8f) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         check_eq("a_clk_out", int'(clk_a), x.clk_a);
         check_eq("a_sync",    int'(sync_a), x.sync_a);
         check_eq("a_running", int'(run_a), x.run_a);
         check_eq("a_locked",  int'(lock_a), x.lock_a);
         check_eq("b_clk_out", int'(clk_b), x.clk_b);
         check_eq("b_sync",    int'(sync_b), x.sync_b);
         check_eq("b_running", int'(run_b), x.run_b);
         check_eq("b_locked",  int'(lock_b), x.lock_b);
         check_eq("a_sync_idle", int'(sync_a & ~run_a), 0);
         check_eq("b_sync_idle", int'(sync_b & ~run_b), 0);
      end
   end

   initial begin
      repeat (3) cycle(1, 0);
      check_eq("rst_clk", int'(clk_a), 0);
      check_eq("rst_run", int'(run_a), 0);
      check_eq("rst_lock", int'(lock_a), 0);
      repeat (2) cycle(0, 0);
      check_eq("idle_hold", int'(run_a), 0);

      // Start-up sequence from E0.
      cycle(0, 1);
      check_eq("e0_run", int'(run_a), 1);
      check_eq("e0_clk", int'(clk_a), 0);
      cycle(0, 1);
      check_eq("e1_clk", int'(clk_a), 1);
      repeat (6) cycle(0, 1);
      check_eq("e7_clk", int'(clk_a), 7);
      check_eq("e7_sync", int'(sync_a), 1);
      cycle(0, 1);
      check_eq("e8_clk", int'(clk_a), 0);
      check_eq("e8_lock", int'(lock_a), 0);
      repeat (7) cycle(0, 1);
      check_eq("e15_lock", int'(lock_a), 0);
      cycle(0, 1);
      check_eq("e16_lock", int'(lock_a), 1);
      check_eq("b_lock_early", int'(lock_b), 1);

      // Drain from cnt=3.
      repeat (3) cycle(0, 1);
      check_eq("pre_drain_cnt", int'(clk_a), 3);
      cycle(0, 0);
      check_eq("drain_cnt4", int'(clk_a), 4);
      check_eq("drain_unlock", int'(lock_a), 0);
      check_eq("drain_run", int'(run_a), 1);
      repeat (3) cycle(0, 0);
      check_eq("drain_cnt7", int'(clk_a), 7);
      cycle(0, 0);
      check_eq("drain_end_cnt", int'(clk_a), 0);
      check_eq("drain_end_run", int'(run_a), 0);

      // Resume during drain.
      repeat (3) cycle(0, 1);
      check_eq("resume_pre", int'(clk_a), 2);
      repeat (2) cycle(0, 0);
      cycle(0, 1);
      check_eq("resume_cnt", int'(clk_a), 5);
      check_eq("resume_run", int'(run_a), 1);
      repeat (20) cycle(0, 1);

      // Reset mid-run at cnt=5.
      for (int i = 0; i < 16 && ma_cnt != 5; i++) cycle(0, 1);
      check_eq("pre_rst_cnt", int'(clk_a), 5);
      cycle(1, 1);
      check_eq("rst_mid_clk", int'(clk_a), 0);
      check_eq("rst_mid_run", int'(run_a), 0);
      cycle(0, 1);
      check_eq("post_rst_run", int'(run_a), 1);

      // Random tail.
      for (int i = 0; i < 300; i++)
         cycle(($urandom_range(0, 49) == 0) ? 1 : 0, ($urandom_range(0, 5) == 0) ? 0 : 1);
      for (int i = 0; i < 100; i++)
         cycle(0, ($urandom_range(0, 1) == 0) ? 0 : 1);

      @(negedge clk_8f);
      #1;
      check_eq("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
